// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, defaults and helpers for the sensor UART link
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        FR_WAIT_SYNC,
        FR_PAYLOAD,
        FR_CHECK
    } frame_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
    localparam int         CLKS_PER_BIT_DEF = 5208;
    localparam int         TIMEOUT_BITS_DEF = 20;
    localparam int         TIMEOUT_CLKS_DEF = TIMEOUT_BITS_DEF * CLKS_PER_BIT_DEF;

    localparam int         MAX_BYTES        = 32;

    // XOR of the low n bytes of data; byte i sits at [i*8+:8]
    function automatic logic [7:0] xor_reduce_bytes(input logic [MAX_BYTES*8-1:0] data,
                                                    input int unsigned            n);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < n) begin
                acc = acc ^ data[i*8 +: 8];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - rx synchroniser and 8N1 byte receiver
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       byte_ferr
);

    localparam int             CW      = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          done_q;
    logic          ferr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    // Leave at mid stop bit so a following start edge is not missed
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            done_q <= 1'b1;
                            data_q <= shift_q;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_data = data_q;
    assign byte_done = done_q;
    assign byte_ferr = ferr_q;

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - sync/payload/checksum frame receiver for the range-sensor link
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int         DEVICES      = 2,
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DEVICES*8-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int            TMO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TW       = $clog2(TMO_CLKS + 1);
    localparam int            IW       = (DEVICES > 1) ? $clog2(DEVICES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CLKS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DEVICES - 1);

    logic [7:0]           byte_data;
    logic                 byte_done;
    logic                 byte_ferr;

    frame_state_e         state_q;
    logic [IW-1:0]        idx_q;
    logic [7:0]           chk_q;
    logic [TW-1:0]        tmo_q;
    logic [DEVICES*8-1:0] shadow_q;
    logic [DEVICES*8-1:0] data_out_q;
    logic                 data_valid_q;
    logic                 frame_err_q;
    logic                 busy_q;
    logic                 tmo_fire;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .byte_ferr (byte_ferr)
    );

    assign tmo_fire = (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FR_WAIT_SYNC;
            idx_q        <= '0;
            chk_q        <= '0;
            tmo_q        <= '0;
            shadow_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                FR_WAIT_SYNC: begin
                    if (byte_done && byte_data == SYNC_BYTE) begin
                        state_q <= FR_PAYLOAD;
                        idx_q   <= '0;
                        chk_q   <= '0;
                        tmo_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FR_PAYLOAD, FR_CHECK: begin
                    // byte_done takes priority over a coincident timeout
                    if (byte_done) begin
                        tmo_q <= '0;
                        if (state_q == FR_PAYLOAD) begin
                            shadow_q[idx_q*8 +: 8] <= byte_data;
                            chk_q <= chk_q ^ byte_data;
                            if (idx_q == IDX_LAST) begin
                                state_q <= FR_CHECK;
                            end else begin
                                idx_q <= idx_q + IW'(1);
                            end
                        end else begin
                            if (byte_data == chk_q) begin
                                data_out_q   <= shadow_q;
                                data_valid_q <= 1'b1;
                            end else begin
                                frame_err_q  <= 1'b1;
                            end
                            state_q <= FR_WAIT_SYNC;
                            busy_q  <= 1'b0;
                        end
                    end else if (byte_ferr || tmo_fire) begin
                        frame_err_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= FR_WAIT_SYNC;
                        tmo_q       <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= FR_WAIT_SYNC;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - randomized self-checking bench for uart_frame_rx
module tb_uart_frame_rx;
    import uart_pkg::*;

    localparam int DEV = 2;
    localparam int CPB = 16;
    localparam int TOB = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [15:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int   valid_cnt     = 0;
    int   err_cnt       = 0;
    int   both_cnt      = 0;
    int   valid_cyc     = -1;
    int   err_cyc       = -1;
    int   busy_fall_cyc = -1;
    logic busy_prev     = 1'b0;
    int   byte_start_cyc = 0;

    logic [15:0] model_data = 16'h0000;

    uart_frame_rx #(
        .DEVICES      (DEV),
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (data_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (data_valid && frame_err) both_cnt++;
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v = b;
        byte_start_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] cs,
                             input logic exp_good, input logic [15:0] exp_data, input string tag);
        int v0, e0, cs_start, off;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        check_eq({tag, "_busy_hi"}, 32'(busy), 32'd1);
        send_byte(p0, 1'b1);
        send_byte(p1, 1'b1);
        send_byte(cs, 1'b1);
        cs_start = byte_start_cyc;
        idle_bits(2);
        check_eq({tag, "_valid_cnt"}, 32'(valid_cnt - v0), 32'(exp_good));
        check_eq({tag, "_err_cnt"}, 32'(err_cnt - e0), 32'(!exp_good));
        check_eq({tag, "_data"}, 32'(data_out), 32'(exp_data));
        check_eq({tag, "_busy_lo"}, 32'(busy), 32'd0);
        if (exp_good) begin
            off = valid_cyc - cs_start;
            check_eq({tag, "_valid_in_stop"}, 32'(off >= 9 * CPB && off < 10 * CPB), 32'd1);
            check_eq({tag, "_busy_fall"}, 32'(busy_fall_cyc), 32'(valid_cyc));
        end else begin
            check_eq({tag, "_busy_fall"}, 32'(busy_fall_cyc), 32'(err_cyc));
        end
    endtask

    initial begin
        int v0, e0, e_end, off;
        logic [7:0] p0, p1, cs, g;
        logic good;

        repeat (4) @(negedge clk);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_valid", 32'(data_valid), 32'd0);
        check_eq("rst_err", 32'(frame_err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle_bits(2);

        run_frame(8'h12, 8'h34, 8'h26, 1'b1, 16'h3412, "good");
        run_frame(8'h56, 8'h78, 8'h00, 1'b0, 16'h3412, "badchk");

        v0 = valid_cnt;
        e0 = err_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle_bits(1);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(2);
        check_eq("garbage_no_busy", 32'(busy), 32'd0);
        check_eq("garbage_no_pulse", 32'((valid_cnt - v0) + (err_cnt - e0)), 32'd0);
        run_frame(8'hAB, 8'hCD, 8'h66, 1'b1, 16'hCDAB, "after_garbage");

        v0 = valid_cnt;
        e0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b1);
        e_end = cyc;
        off = 100000;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (err_cnt != e0) begin
                off = err_cyc - e_end;
                break;
            end
        end
        check_eq("tmo_window", 32'(off >= 306 && off <= 326), 32'd1);
        check_eq("tmo_err_cnt", 32'(err_cnt - e0), 32'd1);
        check_eq("tmo_no_valid", 32'(valid_cnt - v0), 32'd0);
        check_eq("tmo_busy", 32'(busy), 32'd0);
        check_eq("tmo_data", 32'(data_out), 32'h0000CDAB);
        idle_bits(2);
        run_frame(8'h01, 8'h02, 8'h03, 1'b1, 16'h0201, "tmo_recover");

        v0 = valid_cnt;
        e0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h77, 1'b0);
        idle_bits(2);
        check_eq("ferr_err_cnt", 32'(err_cnt - e0), 32'd1);
        check_eq("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
        check_eq("ferr_data", 32'(data_out), 32'h00000201);
        check_eq("ferr_busy", 32'(busy), 32'd0);

        e0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_data", 32'(data_out), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        idle_bits(25);
        check_eq("midrst_no_err", 32'(err_cnt - e0), 32'd0);
        run_frame(8'hA5, 8'h5A, 8'hFF, 1'b1, 16'h5AA5, "sync_as_data");
        model_data = 16'h5AA5;

        for (int f = 0; f < 20; f++) begin
            p0 = 8'($urandom_range(0, 255));
            p1 = 8'($urandom_range(0, 255));
            cs = xor_reduce_bytes({{(MAX_BYTES*8-16){1'b0}}, p1, p0}, 2);
            if ($urandom_range(0, 1) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            good = (cs == (p0 ^ p1));
            if (good) model_data = {p1, p0};
            if ($urandom_range(0, 1) == 1) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h3C;
                send_byte(g, 1'b1);
                idle_bits(1);
            end
            run_frame(p0, p1, cs, good, model_data, $sformatf("rnd%0d", f));
        end

        check_eq("never_both", 32'(both_cnt), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
